// File: rtl/cam_lookup_ctrl_if.sv
// Request/response bundle between the lookup pipeline, the table-fill agent and
// the CAM controller. The controller connects through the slave modport.
interface cam_lookup_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int TAG_WIDTH  = 8
);
    logic                  flush;
    logic                  srch_req;
    logic [TAG_WIDTH-1:0]  srch_tag;
    logic                  srch_gnt;
    logic                  wr_req;
    logic [TAG_WIDTH-1:0]  wr_tag;
    logic                  wr_gnt;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  wr_done;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  full;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output flush, srch_req, srch_tag, wr_req, wr_tag,
        input  srch_gnt, wr_gnt, rsp_valid, rsp_hit, rsp_addr,
               wr_done, wr_err, wr_addr, full, count
    );

    modport slave (
        input  flush, srch_req, srch_tag, wr_req, wr_tag,
        output srch_gnt, wr_gnt, rsp_valid, rsp_hit, rsp_addr,
               wr_done, wr_err, wr_addr, full, count
    );
endinterface

// File: rtl/cam_lookup_ctrl.sv
// Small tag CAM shared between one search requester and one write requester.
// Search returns the lowest-index valid match; writes fill the lowest free slot.
module cam_lookup_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = (1 << ADDR_WIDTH),
    parameter int TAG_WIDTH  = 8
) (
    input logic               clk,
    input logic               reset,
    cam_lookup_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESULT = 2'd2,
        WRITE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_SEARCH = 1'b0,
        OP_WRITE  = 1'b1
    } op_t;

    state_t                state_q, state_d;
    op_t                   last_op_q, last_op_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      match_q, match_d;
    logic [TAG_WIDTH-1:0]  tag_q [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d [DEPTH];
    logic [TAG_WIDTH-1:0]  stag_q, stag_d;
    logic [TAG_WIDTH-1:0]  wtag_q, wtag_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;

    logic [ADDR_WIDTH-1:0] free_idx;
    logic [ADDR_WIDTH-1:0] hit_idx;

    logic                  srch_gnt;
    logic                  wr_gnt;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  wr_done;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        free_idx = '0;
        hit_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = ADDR_WIDTH'(i);
            end
            if (match_q[i]) begin
                hit_idx = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_op_d = last_op_q;
        valid_d   = valid_q;
        match_d   = match_q;
        tag_d     = tag_q;
        stag_d    = stag_q;
        wtag_d    = wtag_q;
        srch_gnt  = 1'b0;
        wr_gnt    = 1'b0;
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_addr  = '0;
        wr_done   = 1'b0;
        wr_err    = 1'b0;
        wr_addr   = '0;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.srch_req && (!bus.wr_req || last_op_q == OP_WRITE)) begin
                    srch_gnt  = 1'b1;
                    stag_d    = bus.srch_tag;
                    last_op_d = OP_SEARCH;
                    state_d   = SEARCH;
                end else if (bus.wr_req) begin
                    wr_gnt    = 1'b1;
                    wtag_d    = bus.wr_tag;
                    last_op_d = OP_WRITE;
                    state_d   = WRITE;
                end
            end

            SEARCH: begin
                for (int i = 0; i < DEPTH; i++) begin
                    match_d[i] = valid_q[i] && (tag_q[i] == stag_q);
                end
                state_d = RESULT;
            end

            RESULT: begin
                rsp_valid = 1'b1;
                rsp_hit   = |match_q;
                rsp_addr  = hit_idx;
                state_d   = IDLE;
            end

            WRITE: begin
                wr_done = 1'b1;
                if (full_q) begin
                    wr_err = 1'b1;
                end else begin
                    valid_d[free_idx] = 1'b1;
                    tag_d[free_idx]   = wtag_q;
                    wr_addr           = free_idx;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Occupancy is registered from the post-edge valid bits so it never lags a write or flush.
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{ADDR_WIDTH{1'b0}}, valid_d[i]};
        end
        full_d = &valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_op_q <= OP_WRITE;
            valid_q   <= '0;
            match_q   <= '0;
            stag_q    <= '0;
            wtag_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            stag_q    <= stag_d;
            wtag_q    <= wtag_d;
            count_q   <= count_d;
            full_q    <= full_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.srch_gnt  = srch_gnt;
    assign bus.wr_gnt    = wr_gnt;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_hit   = rsp_hit;
    assign bus.rsp_addr  = rsp_addr;
    assign bus.wr_done   = wr_done;
    assign bus.wr_err    = wr_err;
    assign bus.wr_addr   = wr_addr;
    assign bus.full      = full_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl: a vector table drives single operations, a scoreboard
// queue holds the expected response of every granted op until the DUT produces it.
module tb_cam_lookup_ctrl;

    localparam int AW = 3;
    localparam int TW = 8;
    localparam logic [1:0] K_SRCH  = 2'd0;
    localparam logic [1:0] K_WR    = 2'd1;
    localparam logic [1:0] K_FLUSH = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] tag;
        logic       exp_flag;
        logic [2:0] exp_addr;
        logic [3:0] exp_count;
        logic       exp_full;
    } vec_t;

    typedef struct {
        logic       is_wr;
        logic       flag;
        logic [2:0] addr;
        int         gnt_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cam_lookup_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    cam_lookup_ctrl #(.ADDR_WIDTH(AW), .DEPTH(8), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[18];
    vec_t post[3];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   resp_cnt    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every response pulse must match the oldest outstanding grant, including its latency.
    always @(negedge clk) begin
        if (!reset && (bus.rsp_valid || bus.wr_done)) begin
            resp_cnt++;
            check_output("response_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_output("resp_kind", {bus.rsp_valid, bus.wr_done}, mon_e.is_wr ? 2'b01 : 2'b10);
                check_output("resp_flag", bus.rsp_valid ? bus.rsp_hit : bus.wr_err, mon_e.flag);
                check_output("resp_addr", bus.rsp_valid ? bus.rsp_addr : bus.wr_addr, mon_e.addr);
                check_output("resp_latency", cyc - mon_e.gnt_cyc, mon_e.is_wr ? 1 : 2);
            end
        end
    end

    task automatic apply_stimulus(input vec_t v, input string name);
        int snap;
        int waited;
        bit got;
        if (v.kind == K_FLUSH) begin
            bus.flush = 1'b1;
            @(posedge clk);
            #1 bus.flush = 1'b0;
        end else begin
            if (v.kind == K_WR) begin
                bus.wr_tag = v.tag;
                bus.wr_req = 1'b1;
            end else begin
                bus.srch_tag = v.tag;
                bus.srch_req = 1'b1;
            end
            snap   = resp_cnt;
            got    = 1'b0;
            waited = 0;
            #1;
            while (!got && waited < 20) begin
                if ((v.kind == K_WR && bus.wr_gnt) || (v.kind == K_SRCH && bus.srch_gnt)) begin
                    got = 1'b1;
                end else begin
                    @(negedge clk);
                    #1;
                    waited++;
                end
            end
            check_output({name, "_gnt"}, got, 1);
            if (got) sb_q.push_back('{v.kind == K_WR, v.exp_flag, v.exp_addr, cyc});
            @(posedge clk);
            #1;
            bus.srch_req = 1'b0;
            bus.wr_req   = 1'b0;
            waited = 0;
            while (resp_cnt == snap && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check_output({name, "_done"}, resp_cnt != snap, 1);
        end
        @(negedge clk);
        #1;
        check_output({name, "_count"}, bus.count, v.exp_count);
        check_output({name, "_full"}, bus.full, v.exp_full);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   grants;
        int   waited;
        int   nw;
        int   snap;
        logic [3:0] order;

        vecs[0]  = '{K_SRCH,  8'h55, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[1]  = '{K_WR,    8'hA0, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[2]  = '{K_WR,    8'hA1, 1'b0, 3'd1, 4'd2, 1'b0};
        vecs[3]  = '{K_WR,    8'hA0, 1'b0, 3'd2, 4'd3, 1'b0};
        vecs[4]  = '{K_SRCH,  8'hA0, 1'b1, 3'd0, 4'd3, 1'b0};
        vecs[5]  = '{K_SRCH,  8'hA1, 1'b1, 3'd1, 4'd3, 1'b0};
        vecs[6]  = '{K_WR,    8'hB3, 1'b0, 3'd3, 4'd4, 1'b0};
        vecs[7]  = '{K_WR,    8'hB4, 1'b0, 3'd4, 4'd5, 1'b0};
        vecs[8]  = '{K_WR,    8'hB5, 1'b0, 3'd5, 4'd6, 1'b0};
        vecs[9]  = '{K_WR,    8'hB6, 1'b0, 3'd6, 4'd7, 1'b0};
        vecs[10] = '{K_WR,    8'hB7, 1'b0, 3'd7, 4'd8, 1'b1};
        vecs[11] = '{K_WR,    8'hC0, 1'b1, 3'd0, 4'd8, 1'b1};
        vecs[12] = '{K_SRCH,  8'hB7, 1'b1, 3'd7, 4'd8, 1'b1};
        vecs[13] = '{K_SRCH,  8'hC0, 1'b0, 3'd0, 4'd8, 1'b1};
        vecs[14] = '{K_FLUSH, 8'h00, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[15] = '{K_SRCH,  8'hA0, 1'b0, 3'd0, 4'd0, 1'b0};
        vecs[16] = '{K_WR,    8'hD0, 1'b0, 3'd0, 4'd1, 1'b0};
        vecs[17] = '{K_SRCH,  8'hD0, 1'b1, 3'd0, 4'd1, 1'b0};

        post[0]  = '{K_SRCH,  8'hE0, 1'b0, 3'd0, 4'd0, 1'b0};
        post[1]  = '{K_WR,    8'hF0, 1'b0, 3'd0, 4'd1, 1'b0};
        post[2]  = '{K_SRCH,  8'hF0, 1'b1, 3'd0, 4'd1, 1'b0};

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.srch_req = 1'b0;
        bus.srch_tag = '0;
        bus.wr_req   = 1'b0;
        bus.wr_tag   = '0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_outputs",
                     {bus.srch_gnt, bus.wr_gnt, bus.rsp_valid, bus.wr_done, bus.full, bus.count}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        $display("[TB] single-operation vector table");
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Both requesters held on an empty table: first tie after reset goes to search.
        $display("[TB] held search+write arbitration");
        pulse_reset();
        bus.srch_tag = 8'hE0;
        bus.wr_tag   = 8'hE0;
        bus.srch_req = 1'b1;
        bus.wr_req   = 1'b1;
        grants = 0;
        waited = 0;
        nw     = 0;
        order  = '0;
        #1;
        while (grants < 4 && waited < 40) begin
            if (bus.srch_gnt || bus.wr_gnt) begin
                order[grants] = bus.wr_gnt;
                if (bus.wr_gnt) begin
                    sb_q.push_back('{1'b1, 1'b0, nw[2:0], cyc});
                    nw++;
                end else begin
                    sb_q.push_back('{1'b0, nw > 0, 3'd0, cyc});
                end
                grants++;
                if (grants == 4) begin
                    @(posedge clk);
                    #1;
                    bus.srch_req = 1'b0;
                    bus.wr_req   = 1'b0;
                end
            end
            if (grants < 4) begin
                @(negedge clk);
                #1;
                waited++;
            end
        end
        check_output("arb_grants", grants, 4);
        check_output("arb_order", order, 4'b1010);
        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_output("arb_drained", sb_q.size(), 0);
        @(negedge clk);
        #1;
        check_output("arb_count", bus.count, 2);

        // Reset lands while a search is in the SEARCH state; its response must never appear.
        $display("[TB] reset during search");
        bus.srch_tag = 8'hE0;
        bus.srch_req = 1'b1;
        #1;
        check_output("abort_gnt", bus.srch_gnt, 1);
        @(posedge clk);
        #1;
        bus.srch_req = 1'b0;
        snap  = resp_cnt;
        reset = 1'b1;
        #1;
        check_output("abort_outputs",
                     {bus.srch_gnt, bus.wr_gnt, bus.rsp_valid, bus.wr_done, bus.rsp_hit, bus.full, bus.count}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_output("abort_no_response", resp_cnt - snap, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(post[i], $sformatf("p%0d", i));
        end
        check_output("final_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
